// File: rtl/mips_if.sv
// rtl/mips_if.sv - memory and commit-trace bus between mips_cpu and its environment
interface mips_if;
    logic [31:0] macroscopic_pc;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_rdata;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;

    modport master (
        output macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen,
               m_inst_addr, w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
        input  i_inst_rdata, m_data_rdata
    );

    modport slave (
        input  macroscopic_pc, i_inst_addr, m_data_addr, m_data_wdata, m_data_byteen,
               m_inst_addr, w_grf_we, w_grf_addr, w_grf_wdata, w_inst_addr,
        output i_inst_rdata, m_data_rdata
    );
endinterface

// File: rtl/mips_cpu.sv
// rtl/mips_cpu.sv - single-cycle MIPS-subset CPU with CP0 and one hardware interrupt
// Optional address-alignment exceptions are enabled by defining ADDR_EXC_EN.
module mips_cpu #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  interrupt,
    mips_if.master bus
);
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

    logic [31:0] pc, sr, epc;
    logic        cause_ip12;
    logic [4:0]  exc_code;
    logic [31:0] gpr [32];

    logic [31:0] inst;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sx, imm_zx, rs_val, rt_val, pc_plus4, cause_val, cp0_rd;

    assign inst     = bus.i_inst_rdata;
    assign op       = inst[31:26];
    assign rs       = inst[25:21];
    assign rt       = inst[20:16];
    assign rd       = inst[15:11];
    assign shamt    = inst[10:6];
    assign funct    = inst[5:0];
    assign imm_sx   = {{16{inst[15]}}, inst[15:0]};
    assign imm_zx   = {16'b0, inst[15:0]};
    assign rs_val   = (rs == 5'd0) ? 32'd0 : gpr[rs];
    assign rt_val   = (rt == 5'd0) ? 32'd0 : gpr[rt];
    assign pc_plus4 = pc + 32'd4;
    assign cause_val = {19'b0, cause_ip12, 5'b0, exc_code, 2'b00};

    always_comb begin
        cp0_rd = 32'd0;
        case (rd)
            5'd12:   cp0_rd = sr;
            5'd13:   cp0_rd = cause_val;
            5'd14:   cp0_rd = epc;
            default: cp0_rd = 32'd0;
        endcase
    end

    logic        legal, reg_we, is_lw, is_sw, is_mtc0, is_eret;
    logic [4:0]  dst;
    logic [31:0] res, pc_tgt, data_addr;

    assign data_addr = rs_val + imm_sx;

    always_comb begin
        legal = 1'b1; reg_we = 1'b0; dst = rt; res = 32'd0;
        is_lw = 1'b0; is_sw = 1'b0; is_mtc0 = 1'b0; is_eret = 1'b0;
        pc_tgt = pc_plus4;
        case (op)
            6'h00: begin
                dst = rd;
                case (funct)
                    6'h00: begin reg_we = 1'b1; res = rt_val << shamt; end
                    6'h21: begin reg_we = 1'b1; res = rs_val + rt_val; end
                    6'h23: begin reg_we = 1'b1; res = rs_val - rt_val; end
                    6'h24: begin reg_we = 1'b1; res = rs_val & rt_val; end
                    6'h25: begin reg_we = 1'b1; res = rs_val | rt_val; end
                    6'h2A: begin reg_we = 1'b1; res = {31'b0, $signed(rs_val) < $signed(rt_val)}; end
                    6'h2B: begin reg_we = 1'b1; res = {31'b0, rs_val < rt_val}; end
                    6'h08: pc_tgt = rs_val;
                    default: legal = 1'b0;
                endcase
            end
            6'h0D: begin reg_we = 1'b1; res = rs_val | imm_zx; end
            6'h09: begin reg_we = 1'b1; res = rs_val + imm_sx; end
            6'h0F: begin reg_we = 1'b1; res = {inst[15:0], 16'b0}; end
            6'h23: begin reg_we = 1'b1; is_lw = 1'b1; res = bus.m_data_rdata; end
            6'h2B: is_sw = 1'b1;
            6'h04: if (rs_val == rt_val) pc_tgt = pc_plus4 + {imm_sx[29:0], 2'b00};
            6'h05: if (rs_val != rt_val) pc_tgt = pc_plus4 + {imm_sx[29:0], 2'b00};
            6'h02: pc_tgt = {pc[31:28], inst[25:0], 2'b00};
            6'h03: begin
                pc_tgt = {pc[31:28], inst[25:0], 2'b00};
                reg_we = 1'b1; dst = 5'd31; res = pc_plus4;
            end
            6'h10: begin
                if (rs == 5'd0) begin
                    reg_we = 1'b1; res = cp0_rd;
                end else if (rs == 5'd4) begin
                    is_mtc0 = 1'b1;
                end else if (inst == 32'h4200_0018) begin
                    is_eret = 1'b1; pc_tgt = epc;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    // Trap arbitration: interrupt first, then fetch/RI/data faults in that order.
    logic       int_req, fetch_adel, data_ade, trap, commit;
    logic [4:0] trap_code;

    assign int_req = interrupt & sr[12] & sr[0] & ~sr[1];
`ifdef ADDR_EXC_EN
    assign fetch_adel = (pc[1:0] != 2'b00);
    assign data_ade   = (is_lw | is_sw) & (data_addr[1:0] != 2'b00);
`else
    assign fetch_adel = 1'b0;
    assign data_ade   = 1'b0;
`endif

    always_comb begin
        trap = 1'b1; trap_code = 5'd0;
        if (int_req)         trap_code = 5'd0;
        else if (fetch_adel) trap_code = 5'd4;
        else if (!legal)     trap_code = 5'd10;
        else if (data_ade)   trap_code = is_lw ? 5'd4 : 5'd5;
        else                 trap = 1'b0;
    end

    assign commit = reset & ~trap;

    assign bus.macroscopic_pc = pc;
    assign bus.i_inst_addr    = pc;
    assign bus.m_inst_addr    = pc;
    assign bus.w_inst_addr    = pc;
    assign bus.m_data_addr    = data_addr;
    assign bus.m_data_wdata   = rt_val;
    assign bus.m_data_byteen  = (commit & is_sw) ? 4'b1111 : 4'b0000;
    assign bus.w_grf_we       = commit & reg_we;
    assign bus.w_grf_addr     = dst;
    assign bus.w_grf_wdata    = res;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
        end else if (commit && reg_we && dst != 5'd0) begin
            gpr[dst] <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC; sr <= 32'd0; epc <= 32'd0;
            cause_ip12 <= 1'b0; exc_code <= 5'd0;
        end else begin
            cause_ip12 <= interrupt;
            if (trap) begin
                epc      <= pc;
                sr[1]    <= 1'b1;
                exc_code <= trap_code;
                pc       <= HANDLER_PC;
            end else begin
                pc <= pc_tgt;
                if (is_eret) sr[1] <= 1'b0;
                if (is_mtc0 && rd == 5'd12) sr  <= rt_val & SR_MASK;
                if (is_mtc0 && rd == 5'd14) epc <= rt_val;
            end
        end
    end
endmodule

// File: tb/tb_mips_cpu.sv
// tb/tb_mips_cpu.sv - directed program with a per-cycle expected commit trace for mips_cpu
module tb_mips_cpu;
    logic clk = 1'b0;
    logic reset;
    logic interrupt;

    always #5 clk = ~clk;

    mips_if bus ();

    mips_cpu dut (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .bus       (bus)
    );

    logic [31:0] imain [64];
    logic [31:0] ihnd  [16];
    logic [31:0] dmem  [64];

    function automatic logic [31:0] fetch(input logic [31:0] a);
        logic [31:0] off;
        if (a >= 32'h3000 && a < 32'h3100) begin
            off = a - 32'h3000;
            return imain[off[7:2]];
        end
        if (a >= 32'h4180 && a < 32'h41C0) begin
            off = a - 32'h4180;
            return ihnd[off[5:2]];
        end
        return 32'd0;
    endfunction

    assign bus.i_inst_rdata = fetch(bus.i_inst_addr);
    assign bus.m_data_rdata = dmem[bus.m_data_addr[7:2]];

    always @(posedge clk)
        if (bus.m_data_byteen != 4'b0 && bus.m_data_addr < 32'h100)
            dmem[bus.m_data_addr[7:2]] <= bus.m_data_wdata;

    typedef struct {
        logic [31:0] pc;
        logic        irq;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [3:0]  be;
        logic        mchk;
        logic [31:0] ma;
        logic [31:0] md;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] pc, input logic irq, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] be,
                                input logic mchk, input logic [31:0] ma, input logic [31:0] md);
        vec_t v;
        v.pc = pc; v.irq = irq; v.we = we; v.wa = wa; v.wd = wd;
        v.be = be; v.mchk = mchk; v.ma = ma; v.md = md;
        return v;
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam int NV = 27;
    vec_t vecs [NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin imain[i] = 32'd0; dmem[i] = 32'd0; end
        for (int i = 0; i < 16; i++) ihnd[i] = 32'd0;

        imain[0]  = 32'h3401_1234; // ori  $1,$0,0x1234
        imain[1]  = 32'h3C02_ABCD; // lui  $2,0xABCD
        imain[2]  = 32'hAC02_0008; // sw   $2,8($0)
        imain[3]  = 32'h8C03_0008; // lw   $3,8($0)
        imain[4]  = 32'h1000_0002; // beq  $0,$0,2
        imain[5]  = 32'h3405_DEAD; // skipped
        imain[6]  = 32'h3405_BEEF; // skipped
        imain[7]  = 32'h0C00_0C09; // jal  0x3024
        imain[8]  = 32'hFC00_0000; // reserved opcode
        imain[9]  = 32'h0023_2021; // addu $4,$1,$3
        imain[10] = 32'h0023_3023; // subu $6,$1,$3
        imain[11] = 32'h0061_382A; // slt  $7,$3,$1
        imain[12] = 32'h0061_402B; // sltu $8,$3,$1
        imain[13] = 32'h2409_FFFF; // addiu $9,$0,-1
        imain[14] = 32'h1421_0005; // bne  $1,$1,5
        imain[15] = 32'h340A_1001; // ori  $10,$0,0x1001
        imain[16] = 32'h408A_6000; // mtc0 $10,$12
        imain[17] = 32'h0022_6024; // and  $12,$1,$2
        imain[18] = 32'h0022_6825; // or   $13,$1,$2
        imain[19] = 32'h340E_7777; // ori  $14,$0,0x7777
        imain[20] = 32'h400F_6000; // mfc0 $15,$12
        imain[21] = 32'h03E0_0008; // jr   $31
        ihnd[0]   = 32'h401A_7000; // mfc0 $26,$14
        ihnd[1]   = 32'h401B_6800; // mfc0 $27,$13
        ihnd[2]   = 32'hAC00_7F20; // sw   $0,0x7F20($0)
        ihnd[3]   = 32'h4200_0018; // eret

        //              pc           irq  we  wa     wd            be      mchk ma           md
        vecs[0]  = mk(32'h3000, 0, 1, 5'd1,  32'h0000_1234, 4'h0, 0, 32'h0,    32'h0);
        vecs[1]  = mk(32'h3004, 0, 1, 5'd2,  32'hABCD_0000, 4'h0, 0, 32'h0,    32'h0);
        vecs[2]  = mk(32'h3008, 0, 0, 5'd0,  32'h0,         4'hF, 1, 32'h8,    32'hABCD_0000);
        vecs[3]  = mk(32'h300C, 0, 1, 5'd3,  32'hABCD_0000, 4'h0, 1, 32'h8,    32'h0);
        vecs[4]  = mk(32'h3010, 0, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[5]  = mk(32'h301C, 0, 1, 5'd31, 32'h0000_3020, 4'h0, 0, 32'h0,    32'h0);
        vecs[6]  = mk(32'h3024, 0, 1, 5'd4,  32'hABCD_1234, 4'h0, 0, 32'h0,    32'h0);
        vecs[7]  = mk(32'h3028, 0, 1, 5'd6,  32'h5433_1234, 4'h0, 0, 32'h0,    32'h0);
        vecs[8]  = mk(32'h302C, 0, 1, 5'd7,  32'h0000_0001, 4'h0, 0, 32'h0,    32'h0);
        vecs[9]  = mk(32'h3030, 0, 1, 5'd8,  32'h0000_0000, 4'h0, 0, 32'h0,    32'h0);
        vecs[10] = mk(32'h3034, 0, 1, 5'd9,  32'hFFFF_FFFF, 4'h0, 0, 32'h0,    32'h0);
        vecs[11] = mk(32'h3038, 0, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[12] = mk(32'h303C, 1, 1, 5'd10, 32'h0000_1001, 4'h0, 0, 32'h0,    32'h0);
        vecs[13] = mk(32'h3040, 1, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[14] = mk(32'h3044, 0, 1, 5'd12, 32'h0000_0000, 4'h0, 0, 32'h0,    32'h0);
        vecs[15] = mk(32'h3048, 0, 1, 5'd13, 32'hABCD_1234, 4'h0, 0, 32'h0,    32'h0);
        vecs[16] = mk(32'h304C, 1, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[17] = mk(32'h4180, 1, 1, 5'd26, 32'h0000_304C, 4'h0, 0, 32'h0,    32'h0);
        vecs[18] = mk(32'h4184, 1, 1, 5'd27, 32'h0000_1000, 4'h0, 0, 32'h0,    32'h0);
        vecs[19] = mk(32'h4188, 1, 0, 5'd0,  32'h0,         4'hF, 1, 32'h7F20, 32'h0);
        vecs[20] = mk(32'h418C, 0, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[21] = mk(32'h304C, 0, 1, 5'd14, 32'h0000_7777, 4'h0, 0, 32'h0,    32'h0);
        vecs[22] = mk(32'h3050, 0, 1, 5'd15, 32'h0000_1001, 4'h0, 0, 32'h0,    32'h0);
        vecs[23] = mk(32'h3054, 0, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[24] = mk(32'h3020, 0, 0, 5'd0,  32'h0,         4'h0, 0, 32'h0,    32'h0);
        vecs[25] = mk(32'h4180, 0, 1, 5'd26, 32'h0000_3020, 4'h0, 0, 32'h0,    32'h0);
        vecs[26] = mk(32'h4184, 0, 1, 5'd27, 32'h0000_0028, 4'h0, 0, 32'h0,    32'h0);

        reset = 1'b0;
        interrupt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset pc",     bus.macroscopic_pc, 32'h3000);
        chk("reset we",     {31'b0, bus.w_grf_we}, 32'd0);
        chk("reset byteen", {28'b0, bus.m_data_byteen}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            interrupt = vecs[i].irq;
            #1;
            chk($sformatf("v%0d pc", i), bus.macroscopic_pc, vecs[i].pc);
            chk($sformatf("v%0d fetch", i), bus.i_inst_addr, vecs[i].pc);
            chk($sformatf("v%0d we", i), {31'b0, bus.w_grf_we}, {31'b0, vecs[i].we});
            chk($sformatf("v%0d byteen", i), {28'b0, bus.m_data_byteen}, {28'b0, vecs[i].be});
            if (vecs[i].we) begin
                chk($sformatf("v%0d waddr", i), {27'b0, bus.w_grf_addr}, {27'b0, vecs[i].wa});
                chk($sformatf("v%0d wdata", i), bus.w_grf_wdata, vecs[i].wd);
                chk($sformatf("v%0d winst", i), bus.w_inst_addr, vecs[i].pc);
            end
            if (vecs[i].mchk) begin
                chk($sformatf("v%0d maddr", i), bus.m_data_addr, vecs[i].ma);
                chk($sformatf("v%0d minst", i), bus.m_inst_addr, vecs[i].pc);
            end
            if (vecs[i].be != 4'h0)
                chk($sformatf("v%0d mwdata", i), bus.m_data_wdata, vecs[i].md);
            @(negedge clk);
        end

        // Reset asserted over the handler's store: the store must be suppressed.
        interrupt = 1'b0;
        reset = 1'b0;
        #1;
        chk("mid-reset pc before edge", bus.macroscopic_pc, 32'h4188);
        chk("mid-reset byteen", {28'b0, bus.m_data_byteen}, 32'd0);
        chk("mid-reset we", {31'b0, bus.w_grf_we}, 32'd0);
        @(negedge clk);
        chk("mid-reset pc after edge", bus.macroscopic_pc, 32'h3000);
        reset = 1'b1;
        #1;
        chk("restart ori wdata", bus.w_grf_wdata, 32'h0000_1234);
        @(negedge clk);
        @(negedge clk);
        // GPRs were cleared: $2 is fresh from lui, so sw at 0x3008 stores 0xABCD0000 again.
        chk("restart sw wdata", bus.m_data_wdata, 32'hABCD_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
